// File: rtl/microwave_ctrl_gen.sv
// Microwave oven controller: one-hot keypad entry of a BCD MM:SS time, real-time
// countdown on 7-segment displays, pause/resume, DONE state and duty-cycled magnetron.
module microwave_ctrl_gen #(
    parameter int CLK_PER_SEC = 100,
    parameter int MIN_DIGITS  = 2,
    parameter int POWER_STEPS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    door_closed,
    input  logic [3:0]              power_level,
    output logic [6:0]              sec_ones_segs,
    output logic [6:0]              sec_tens_segs,
    output logic [7*MIN_DIGITS-1:0] mins_segs,
    output logic                    mag_on,
    output logic                    done
);

    localparam int NDIG = 2 + MIN_DIGITS;
    localparam int PSW  = $clog2(CLK_PER_SEC);
    localparam int PW   = ($clog2(POWER_STEPS + 1) > 4) ? $clog2(POWER_STEPS + 1) : 4;
    localparam logic [6:0] SEG_ZERO = 7'h3F;

    typedef enum logic [1:0] {IDLE, COOKING, PAUSED, DONE} state_t;

    state_t               state, state_nx;
    logic [NDIG-1:0][3:0] tm, tm_nx, tm_dec;
    logic [PSW-1:0]       presc, presc_nx;
    logic [PW-1:0]        duty, duty_nx;
    logic [PW-1:0]        power, power_nx;
    logic [9:0]           key_prev;
    logic [3:0]           key_digit;
    logic                 key_event, key_single, tick, mag_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign key_event  = (keypad != '0) && (key_prev == '0);
    assign key_single = ((keypad & (keypad - 10'd1)) == '0);
    assign tick       = (presc == PSW'(CLK_PER_SEC - 1));

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++)
            if (keypad[i]) key_digit = 4'(i);
    end

    // Borrow ripples upward: seconds-tens wraps to 5, every other digit to 9.
    always_comb begin
        logic borrow;
        tm_dec = tm;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (tm[i] != 4'd0) begin
                    tm_dec[i] = tm[i] - 4'd1;
                    borrow    = 1'b0;
                end else begin
                    tm_dec[i] = (i == 1) ? 4'd5 : 4'd9;
                end
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        tm_nx    = tm;
        presc_nx = presc;
        duty_nx  = duty;
        power_nx = power;
        if (!clearn) begin
            state_nx = IDLE;
            tm_nx    = '0;
            presc_nx = '0;
            duty_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_event && key_single)
                        tm_nx = {tm[NDIG-2:0], key_digit};
                    // Start looks at the pre-shift time, so a same-cycle key cannot enable it.
                    if (!startn && door_closed && (tm != '0)) begin
                        state_nx = COOKING;
                        presc_nx = '0;
                        duty_nx  = '0;
                        power_nx = (power_level == 4'd0) ? PW'(POWER_STEPS) : PW'(power_level);
                    end
                end
                COOKING: begin
                    presc_nx = tick ? '0 : presc + PSW'(1);
                    if (tick) begin
                        tm_nx   = tm_dec;
                        duty_nx = (duty == PW'(POWER_STEPS - 1)) ? '0 : duty + PW'(1);
                    end
                    if (tick && ((tm == '0) || (tm_dec == '0))) begin
                        state_nx = DONE;
                        tm_nx    = '0;
                    end else if (!stopn || !door_closed) begin
                        state_nx = PAUSED;
                    end
                end
                PAUSED: begin
                    if (!startn && door_closed && stopn)
                        state_nx = COOKING;
                end
                DONE: begin
                    if (!door_closed) begin
                        state_nx = IDLE;
                        presc_nx = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        mag_nx = (state_nx == COOKING) && door_closed && (duty_nx < power_nx);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            tm            <= '0;
            presc         <= '0;
            duty          <= '0;
            power         <= '0;
            key_prev      <= '0;
            sec_ones_segs <= SEG_ZERO;
            sec_tens_segs <= SEG_ZERO;
            mins_segs     <= {MIN_DIGITS{SEG_ZERO}};
            mag_on        <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            tm            <= tm_nx;
            presc         <= presc_nx;
            duty          <= duty_nx;
            power         <= power_nx;
            key_prev      <= keypad;
            sec_ones_segs <= seg7(tm_nx[0]);
            sec_tens_segs <= seg7(tm_nx[1]);
            for (int i = 0; i < MIN_DIGITS; i++)
                mins_segs[7*i +: 7] <= seg7(tm_nx[2+i]);
            mag_on        <= mag_nx;
            done          <= (state_nx == DONE);
        end
    end

endmodule
